seg_to_hex_capture: RTL and testbench
=====================================

Name: seg_to_hex_capture

Overview:
- Reverse path of the hex-to-7-segment display driver.
- Sniffs a multiplexed, active-low 7-segment bus (8 segment lines including dp, plus active-low digit enables) and recovers the displayed hex digits.
- Each pattern is validated for stability before capture; digits are assembled into a full frame and the frame is presented on a valid/ready output.
- Used for display loopback self-test and for capturing panel readings from legacy boards.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 8, consecutive identical cycles required before capture (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
seg  input  8  segment bus; [6:0]=g..a active-low, [7]=dp line (1 = dp off)
an  input  NUM_DIGITS  digit enables, active-low, one-hot when valid
out_ready  input  1  consumer accepts frame
clear_ovr  input  1  one-cycle pulse, clears overrun
out_valid  output  1  frame available
out_hex  output  4*NUM_DIGITS  digit i in bits [4i+3:4i]
out_dp  output  NUM_DIGITS  raw seg[7] per digit
out_err  output  NUM_DIGITS  1 = digit pattern not a legal hex glyph
overrun  output  1  sticky: a completed frame was dropped

Behaviour:
- Reset: synchronous, active-high. All outputs 0; digit/seen registers 0; tracker in WAIT.
- Input stage: seg and an registered once (seg_q, an_q). Logic below uses registered values only.
- Legal select: exactly one bit of an_q is 0. All-ones (blanking) or multiple zeros is illegal.
- Tracker FSM, states WAIT, COUNT, HELD:
  - WAIT: legal select -> COUNT, cnt=1.
  - COUNT: (seg_q,an_q) unchanged and legal -> cnt+1. When cnt reaches STABLE_CYCLES -> capture, go HELD.
  - HELD: no recapture while the pattern is unchanged.
  - Any change or illegal select, in any state: legal -> COUNT, cnt=1; illegal -> WAIT.
  - STABLE_CYCLES=1: capture on the first registered cycle.
- Capture of selected digit i:
  - hex_r[i] = decode(seg_q[6:0]).
  - dp_r[i] = seg_q[7].
  - err_r[i] = pattern not in table; hex_r[i]=0 when err.
  - seen[i] = 1.
  - Re-capture of an already-seen digit overwrites it.
- Decode table (seg[6:0], hex):
  - 40:0, 79:1, 24:2, 30:3, 19:4, 12:5, 02:6, 78:7
  - 00:8, 10:9, 08:A, 03:B, 46:C, 21:D, 06:E, 0E:F
  - Everything else, including 7F blank, is err.
- Frame complete: the cycle after a capture makes seen all-ones.
  - If !out_valid, or out_valid && out_ready in that same cycle: load out_hex/out_dp/out_err from the digit registers including the new capture, out_valid=1.
  - Otherwise: frame dropped, overrun=1.
  - In both cases seen is cleared.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - out_valid drops the next cycle unless a new frame loads in the same cycle.
  - Outputs are stable while out_valid && !out_ready.
- Latency: pattern first present at input in cycle t -> digit capture at the edge ending cycle t+STABLE_CYCLES -> out_valid high in cycle t+STABLE_CYCLES+2 if that was the last missing digit.
- overrun: set as above; cleared by clear_ovr. If set and clear occur in the same cycle, set wins.
- Reset mid-frame: partial seen and digit data are discarded; no frame is emitted.

Decomposition:
- Shared package: seven-segment glyph constants, the same 16 active-low codes used by the display driver, so the encoder and decoder tables share one source.
- Also in the package: SEG_BLANK=7F and NUM_DIGITS default.
- One sub-module: seg_glyph_decode, combinational 7-bit pattern -> {err, hex[3:0]}.

Test Plan:
1. Reset, then digits 0..3 show 1,2,3,4 (an=E,D,B,7; seg=F9,A4,B0,99), each held 10 cycles -> one frame: out_hex=16'h4321, out_dp=4'hF, out_err=0; out_valid exactly 2 cycles after the last capture.
2. Digit 0 seg=C0 held only 7 cycles, then changed (STABLE_CYCLES=8) -> no capture; seen[0] stays 0; no frame.
3. Digit 2 shows 7F (blank) stably -> out_err=4'b0100, out_hex[11:8]=0, other digits decode normally.
4. out_ready held 0 with frame 16'h4321 pending; second full frame 16'hABCD completes -> overrun=1, outputs stay 4321; out_ready=1 -> transfer; clear_ovr -> overrun=0.
5. an=4'b0011 (two enables low) and an=4'hF alternating with valid patterns -> no captures during illegal cycles; counter restarts at 1.
6. rst asserted after 3 of 4 digits captured, then full sequence 5,6,7,8 (seg=92,82,F8,80) -> single frame 16'h8765; no stale data.

Source files
------------

// File: rtl/seg_to_hex_capture_pkg.sv
// Shared seven-segment glyph set (active-low, seg[6:0] = g..a) used by both the
// display encoder and the capture decoder, plus tracker state type.
package seg_to_hex_capture_pkg;

    localparam int NUM_DIGITS_DEFAULT = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic [1:0] {
        TRK_WAIT,
        TRK_COUNT,
        TRK_HELD
    } trk_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] hex);
        logic [6:0] glyph;
        case (hex)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg_to_hex_capture_glyph_decode.sv
// Inverse of the glyph table: 7-bit active-low pattern -> hex digit, err when the
// pattern is not one of the 16 glyphs (blank included).
module seg_glyph_decode
    import seg_to_hex_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       err,
    output logic [3:0] hex
);

    always_comb begin
        err = 1'b1;
        hex = '0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == seg_encode(4'(i))) begin
                err = 1'b0;
                hex = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_to_hex_capture.sv
// Sniffs a multiplexed active-low 7-segment bus, captures each digit once its
// pattern has been stable long enough, and emits complete frames on valid/ready.
module seg_to_hex_capture
    import seg_to_hex_capture_pkg::*;
#(
    parameter int NUM_DIGITS    = NUM_DIGITS_DEFAULT,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    out_ready,
    input  logic                    clear_ovr,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_hex,
    output logic [NUM_DIGITS-1:0]   out_dp,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    overrun
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam bit CAPTURE_ON_FIRST = (STABLE_CYCLES == 1);

    logic [7:0]              seg_q_reg;
    logic [NUM_DIGITS-1:0]   an_q_reg;
    logic [7:0]              seg_prev_reg;
    logic [NUM_DIGITS-1:0]   an_prev_reg;

    trk_state_t              state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [CNT_W-1:0]        cnt_inc;

    logic [NUM_DIGITS-1:0]   sel;
    logic                    legal;
    logic                    changed;
    logic                    restart;
    logic                    stable_hit;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   cap_vec;

    logic                    dec_err;
    logic [3:0]              dec_hex;

    logic [NUM_DIGITS-1:0]   seen_reg;
    logic                    frame_done;
    logic                    frame_load;

    logic [4*NUM_DIGITS-1:0] hex_flat;
    logic [NUM_DIGITS-1:0]   dp_flat;
    logic [NUM_DIGITS-1:0]   err_flat;

    logic                    out_valid_reg;
    logic [4*NUM_DIGITS-1:0] out_hex_reg;
    logic [NUM_DIGITS-1:0]   out_dp_reg;
    logic [NUM_DIGITS-1:0]   out_err_reg;
    logic                    overrun_reg;

    // Input stage; prev copies let the tracker detect any change of (seg, an).
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q_reg    <= '1;
            an_q_reg     <= '1;
            seg_prev_reg <= '1;
            an_prev_reg  <= '1;
        end else begin
            seg_q_reg    <= seg;
            an_q_reg     <= an;
            seg_prev_reg <= seg_q_reg;
            an_prev_reg  <= an_q_reg;
        end
    end

    assign sel        = ~an_q_reg;
    assign legal      = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    assign changed    = (seg_q_reg != seg_prev_reg) || (an_q_reg != an_prev_reg);
    assign restart    = (state_reg == TRK_WAIT) || changed;
    assign cnt_inc    = cnt_reg + CNT_W'(1);
    assign stable_hit = (cnt_inc == CNT_W'(STABLE_CYCLES));

    // cnt_reg holds how many registered cycles the current pattern has been seen.
    always_comb begin
        capture = 1'b0;
        if (legal) begin
            if (restart) begin
                capture = CAPTURE_ON_FIRST;
            end else if (state_reg == TRK_COUNT) begin
                capture = stable_hit;
            end
        end
    end

    assign cap_vec = {NUM_DIGITS{capture}} & sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= TRK_WAIT;
            cnt_reg   <= '0;
        end else if (!legal) begin
            state_reg <= TRK_WAIT;
            cnt_reg   <= '0;
        end else if (restart) begin
            cnt_reg   <= CNT_W'(1);
            state_reg <= CAPTURE_ON_FIRST ? TRK_HELD : TRK_COUNT;
        end else begin
            case (state_reg)
                TRK_COUNT: begin
                    cnt_reg <= cnt_inc;
                    if (stable_hit) begin
                        state_reg <= TRK_HELD;
                    end
                end
                TRK_HELD: begin
                    state_reg <= TRK_HELD;
                end
                default: begin
                    state_reg <= TRK_WAIT;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    seg_glyph_decode u_decode (
        .pattern (seg_q_reg[6:0]),
        .err     (dec_err),
        .hex     (dec_hex)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [3:0] hex_reg;
        logic       dp_reg;
        logic       err_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                hex_reg <= '0;
                dp_reg  <= 1'b0;
                err_reg <= 1'b0;
            end else if (cap_vec[gi]) begin
                hex_reg <= dec_hex;
                dp_reg  <= seg_q_reg[7];
                err_reg <= dec_err;
            end
        end

        assign hex_flat[4*gi +: 4] = hex_reg;
        assign dp_flat[gi]         = dp_reg;
        assign err_flat[gi]        = err_reg;
    end

    // A capture landing in the completion cycle starts the next frame.
    assign frame_done = &seen_reg;
    assign frame_load = frame_done && (!out_valid_reg || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_reg <= '0;
        end else begin
            seen_reg <= (frame_done ? '0 : seen_reg) | cap_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_hex_reg   <= '0;
            out_dp_reg    <= '0;
            out_err_reg   <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            if (frame_load) begin
                out_valid_reg <= 1'b1;
                out_hex_reg   <= hex_flat;
                out_dp_reg    <= dp_flat;
                out_err_reg   <= err_flat;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end

            if (frame_done && !frame_load) begin
                overrun_reg <= 1'b1;
            end else if (clear_ovr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_hex   = out_hex_reg;
    assign out_dp    = out_dp_reg;
    assign out_err   = out_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_seg_to_hex_capture.sv
// Directed bench for seg_to_hex_capture (4 digits, 8-cycle stability window).
module tb_seg_to_hex_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        out_ready;
    logic        clear_ovr;
    logic        out_valid;
    logic [15:0] out_hex;
    logic [3:0]  out_dp;
    logic [3:0]  out_err;
    logic        overrun;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg_to_hex_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .an        (an),
        .out_ready (out_ready),
        .clear_ovr (clear_ovr),
        .out_valid (out_valid),
        .out_hex   (out_hex),
        .out_dp    (out_dp),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    // Drive a pattern for n cycles; returns 1 time unit after the last edge.
    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic transfer();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hold(4'hE, 8'hF9, 3);
        rst = 1'b0;
        hold(4'hF, 8'hFF, 1);
        checks++;
        if ({out_valid, overrun} !== 2'b00) $display("FAIL reset_flags: got %b exp 00", {out_valid, overrun});
        else passed++;
        checks++;
        if ({out_hex, out_dp, out_err} !== 24'h0) $display("FAIL reset_data: got %h exp 000000", {out_hex, out_dp, out_err});
        else passed++;
        $display("reset: valid=%b hex=%h", out_valid, out_hex);
    endtask

    task automatic test_frame();
        hold(4'hE, 8'hF9, 10);
        hold(4'hD, 8'hA4, 10);
        hold(4'hB, 8'hB0, 10);
        hold(4'h7, 8'h99, 9);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL frame_early: got valid=%b exp 0", out_valid);
        else passed++;
        hold(4'h7, 8'h99, 1);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL frame_latency: got valid=%b exp 1", out_valid);
        else passed++;
        checks++;
        if ({out_hex, out_dp, out_err} !== {16'h4321, 4'hF, 4'h0}) $display("FAIL frame_data: got %h exp 4321f0", {out_hex, out_dp, out_err});
        else passed++;
        hold(4'hF, 8'hFF, 3);
        checks++;
        if ({out_valid, out_hex} !== {1'b1, 16'h4321}) $display("FAIL frame_stall: got %h exp 14321", {out_valid, out_hex});
        else passed++;
        transfer();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL frame_transfer: got valid=%b exp 0", out_valid);
        else passed++;
        $display("frame: hex=%h dp=%h err=%h", out_hex, out_dp, out_err);
    endtask

    task automatic test_short_hold();
        hold(4'hE, 8'hC0, 7);
        hold(4'hD, 8'hF9, 10);
        hold(4'hB, 8'hA4, 10);
        hold(4'h7, 8'hB0, 10);
        hold(4'hF, 8'hFF, 4);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL short_no_frame: got valid=%b exp 0", out_valid);
        else passed++;
        hold(4'hE, 8'hC0, 8);
        hold(4'hF, 8'hFF, 2);
        checks++;
        if ({out_valid, out_hex} !== {1'b1, 16'h3210}) $display("FAIL short_exact8: got %h exp 13210", {out_valid, out_hex});
        else passed++;
        transfer();
        $display("short_hold: hex=%h", out_hex);
    endtask

    task automatic test_err_glyph();
        hold(4'hE, 8'h79, 10);
        hold(4'hD, 8'hA4, 10);
        hold(4'hB, 8'hFF, 10);
        hold(4'h7, 8'h99, 10);
        checks++;
        if ({out_valid, out_hex} !== {1'b1, 16'h4021}) $display("FAIL err_hex: got %h exp 14021", {out_valid, out_hex});
        else passed++;
        checks++;
        if (out_err !== 4'b0100) $display("FAIL err_flags: got %b exp 0100", out_err);
        else passed++;
        checks++;
        if (out_dp !== 4'b1110) $display("FAIL err_dp: got %b exp 1110", out_dp);
        else passed++;
        transfer();
        hold(4'hF, 8'hFF, 2);
        $display("err_glyph: hex=%h err=%b dp=%b", out_hex, out_err, out_dp);
    endtask

    task automatic test_overrun();
        hold(4'hE, 8'hF9, 10);
        hold(4'hD, 8'hA4, 10);
        hold(4'hB, 8'hB0, 10);
        hold(4'h7, 8'h99, 10);
        hold(4'hE, 8'hA1, 10);
        hold(4'hD, 8'hC6, 10);
        hold(4'hB, 8'h83, 10);
        hold(4'h7, 8'h88, 10);
        checks++;
        if (overrun !== 1'b1) $display("FAIL ovr_set: got %b exp 1", overrun);
        else passed++;
        checks++;
        if ({out_valid, out_hex} !== {1'b1, 16'h4321}) $display("FAIL ovr_hold: got %h exp 14321", {out_valid, out_hex});
        else passed++;
        hold(4'hF, 8'hFF, 1);
        transfer();
        checks++;
        if ({out_valid, overrun} !== 2'b01) $display("FAIL ovr_sticky: got %b exp 01", {out_valid, overrun});
        else passed++;
        clear_ovr = 1'b1;
        hold(4'hF, 8'hFF, 1);
        clear_ovr = 1'b0;
        checks++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b exp 0", overrun);
        else passed++;
        $display("overrun: hex=%h overrun=%b", out_hex, overrun);
    endtask

    task automatic test_illegal_select();
        hold(4'b0011, 8'hF9, 12);
        hold(4'hF, 8'hF9, 12);
        hold(4'b0011, 8'hF9, 12);
        hold(4'hE, 8'h90, 10);
        hold(4'hD, 8'h80, 10);
        hold(4'hB, 8'hF8, 10);
        hold(4'hF, 8'hFF, 4);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL illegal_no_capture: got valid=%b exp 0", out_valid);
        else passed++;
        hold(4'h7, 8'h82, 5);
        hold(4'hF, 8'h82, 1);
        hold(4'h7, 8'h82, 7);
        hold(4'hF, 8'hFF, 4);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL illegal_restart: got valid=%b exp 0", out_valid);
        else passed++;
        hold(4'h7, 8'h82, 8);
        hold(4'hF, 8'hFF, 2);
        checks++;
        if ({out_valid, out_hex} !== {1'b1, 16'h6789}) $display("FAIL illegal_frame: got %h exp 16789", {out_valid, out_hex});
        else passed++;
        transfer();
        $display("illegal_select: hex=%h", out_hex);
    endtask

    task automatic test_reset_mid_frame();
        hold(4'hE, 8'hF9, 10);
        hold(4'hD, 8'hA4, 10);
        hold(4'hB, 8'hB0, 10);
        rst = 1'b1;
        hold(4'hF, 8'hFF, 2);
        rst = 1'b0;
        hold(4'h7, 8'h80, 10);
        hold(4'hF, 8'hFF, 4);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL rstmid_no_stale: got valid=%b exp 0", out_valid);
        else passed++;
        hold(4'hE, 8'h92, 10);
        hold(4'hD, 8'h82, 10);
        hold(4'hB, 8'hF8, 10);
        hold(4'h7, 8'h80, 10);
        checks++;
        if ({out_valid, out_hex, out_err} !== {1'b1, 16'h8765, 4'h0}) $display("FAIL rstmid_frame: got %h exp 187650", {out_valid, out_hex, out_err});
        else passed++;
        transfer();
        hold(4'hF, 8'hFF, 12);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL rstmid_single: got valid=%b exp 0", out_valid);
        else passed++;
        $display("reset_mid_frame: hex=%h", out_hex);
    endtask

    initial begin
        rst       = 1'b1;
        an        = 4'hF;
        seg       = 8'hFF;
        out_ready = 1'b0;
        clear_ovr = 1'b0;
        test_reset();
        test_frame();
        test_short_hold();
        test_err_glyph();
        test_overrun();
        test_illegal_select();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
